// File: rtl/xbar_arbiter_if.sv
// Crossbar arbiter bus: request/destination inputs and the grant/select
// outputs that drive the 4x4 crossbar mux and serializers.
//   req[i]                input i requests a connection
//   dest[2i+1:2i]         destination output for input i
//   grant[i]              input i is connected to an output
//   out_sel[2j+1:2j]      input index driving output j
//   out_en[j]             output j carries a connection
//   load[j]               frame-start strobe for output j
// master: the requesting side; slave: the arbiter.
interface xbar_arbiter_if;
    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned IDX_W     = 2;

    logic [NUM_PORTS-1:0]         req;
    logic [NUM_PORTS*IDX_W-1:0]   dest;
    logic [NUM_PORTS-1:0]         grant;
    logic [NUM_PORTS*IDX_W-1:0]   out_sel;
    logic [NUM_PORTS-1:0]         out_en;
    logic [NUM_PORTS-1:0]         load;

    modport master (
        output req, dest,
        input  grant, out_sel, out_en, load
    );

    modport slave (
        input  req, dest,
        output grant, out_sel, out_en, load
    );
endinterface

// File: rtl/xbar_arbiter.sv
// 4x4 crossbar arbiter. Each output runs its own IDLE/BUSY FSM with a
// round-robin pointer and a frame hold counter; a granted connection is held
// for exactly FRAME_LEN cycles (legal 2..255) and followed by at least one
// arbitration cycle.
//   clk  system clock, rising edge
//   rst  synchronous, active-high reset
//   bus  xbar_arbiter_if.slave (req/dest in, grant/out_sel/out_en/load out)
module xbar_arbiter #(
    parameter int unsigned FRAME_LEN = 80
) (
    input  logic           clk,
    input  logic           rst,
    xbar_arbiter_if.slave  bus
);
    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned CNT_W     = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e               state_q [NUM_PORTS];
    state_e               state_d [NUM_PORTS];
    logic [IDX_W-1:0]     ptr_q   [NUM_PORTS];
    logic [IDX_W-1:0]     ptr_d   [NUM_PORTS];
    logic [CNT_W-1:0]     cnt_q   [NUM_PORTS];
    logic [CNT_W-1:0]     cnt_d   [NUM_PORTS];
    logic [IDX_W-1:0]     sel_q   [NUM_PORTS];
    logic [IDX_W-1:0]     sel_d   [NUM_PORTS];

    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [NUM_PORTS-1:0] en_q,    en_d;
    logic [NUM_PORTS-1:0] load_q,  load_d;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                state_q[j] <= IDLE;
                ptr_q[j]   <= '0;
                cnt_q[j]   <= '0;
                sel_q[j]   <= '0;
            end
            grant_q <= '0;
            en_q    <= '0;
            load_q  <= '0;
        end else begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                state_q[j] <= state_d[j];
                ptr_q[j]   <= ptr_d[j];
                cnt_q[j]   <= cnt_d[j];
                sel_q[j]   <= sel_d[j];
            end
            grant_q <= grant_d;
            en_q    <= en_d;
            load_q  <= load_d;
        end
    end

    // Per-output next state, round-robin pick and next output values.
    always_comb begin
        logic [NUM_PORTS-1:0] cand;
        logic                 found;
        logic [IDX_W-1:0]     pick;
        logic [IDX_W-1:0]     idx;

        cand    = '0;
        found   = 1'b0;
        pick    = '0;
        idx     = '0;
        grant_d = '0;
        en_d    = '0;
        load_d  = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            state_d[j] = state_q[j];
            ptr_d[j]   = ptr_q[j];
            cnt_d[j]   = cnt_q[j];
            sel_d[j]   = sel_q[j];
        end

        for (int j = 0; j < NUM_PORTS; j++) begin
            // An input already holding a connection is never a candidate, so
            // two outputs cannot claim the same input; a requester names only
            // one destination, so concurrent picks never collide either.
            for (int i = 0; i < NUM_PORTS; i++) begin
                cand[i] = bus.req[i]
                          && (bus.dest[IDX_W*i +: IDX_W] == IDX_W'(j))
                          && !grant_q[i];
            end

            unique case (state_q[j])
                IDLE: begin
                    found = 1'b0;
                    pick  = ptr_q[j];
                    for (int k = 0; k < NUM_PORTS; k++) begin
                        idx = ptr_q[j] + IDX_W'(k);
                        if (!found && cand[idx]) begin
                            found = 1'b1;
                            pick  = idx;
                        end
                    end
                    if (found) begin
                        state_d[j] = BUSY;
                        sel_d[j]   = pick;
                        cnt_d[j]   = CNT_W'(FRAME_LEN - 1);
                        load_d[j]  = 1'b1;
                    end
                end
                BUSY: begin
                    // Counter hits zero on the last connected cycle; the
                    // following cycle is the mandatory arbitration gap.
                    if (cnt_q[j] != '0) begin
                        cnt_d[j] = cnt_q[j] - CNT_W'(1);
                    end else begin
                        state_d[j] = IDLE;
                        ptr_d[j]   = sel_q[j] + IDX_W'(1);
                    end
                end
                default: begin
                    state_d[j] = IDLE;
                end
            endcase

            en_d[j] = (state_d[j] == BUSY);
            if (en_d[j]) begin
                grant_d[sel_d[j]] = 1'b1;
            end
        end
    end

    // Output mapping; out_sel keeps its last value while the output is idle.
    always_comb begin
        bus.out_sel = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            bus.out_sel[IDX_W*j +: IDX_W] = sel_q[j];
        end
    end

    assign bus.grant  = grant_q;
    assign bus.out_en = en_q;
    assign bus.load   = load_q;

endmodule

// File: tb/tb_xbar_arbiter.sv
// Bench for xbar_arbiter: directed scenarios then random traffic, compared
// cycle by cycle against a frame-level reference model through a scoreboard
// queue, plus continuous protocol checks on hold time, exclusivity, load
// strobe and grant consistency.
module tb_xbar_arbiter;
    localparam int FL = 10;

    typedef struct packed {
        logic [3:0] grant;
        logic [7:0] out_sel;
        logic [3:0] out_en;
        logic [3:0] load;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xbar_arbiter_if bus();

    xbar_arbiter #(.FRAME_LEN(FL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: remaining connected cycles, owner and pointer per output.
    int   m_rem[4];
    int   m_own[4];
    int   m_ptr[4];

    logic rec_order = 1'b0;
    int   order0[$];
    logic rst_edge = 1'b1;
    int   run_len[4];
    logic [3:0] prev_en = '0;
    exp_t mon_e;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [3:0] rq,
                              input logic [7:0] ds, output exp_t e);
        logic [3:0] g;
        logic [3:0] ld;
        logic [1:0] d;
        bit         done;
        e  = '0;
        g  = '0;
        ld = '0;
        if (r) begin
            for (int j = 0; j < 4; j++) begin
                m_rem[j] = 0;
                m_own[j] = 0;
                m_ptr[j] = 0;
            end
            return;
        end
        for (int j = 0; j < 4; j++)
            if (m_rem[j] > 0) g[m_own[j]] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if (m_rem[j] > 0) begin
                m_rem[j]--;
                if (m_rem[j] == 0) m_ptr[j] = (m_own[j] + 1) % 4;
            end else begin
                done = 0;
                for (int k = 0; k < 4; k++) begin
                    int i;
                    i = (m_ptr[j] + k) % 4;
                    d = ds[2*i +: 2];
                    if (!done && rq[i] && (int'(d) == j) && !g[i]) begin
                        m_own[j] = i;
                        m_rem[j] = FL;
                        ld[j]    = 1'b1;
                        done     = 1;
                    end
                end
            end
        end
        for (int j = 0; j < 4; j++) begin
            if (m_rem[j] > 0) begin
                e.out_en[j]       = 1'b1;
                e.grant[m_own[j]] = 1'b1;
            end
            e.out_sel[2*j +: 2] = 2'(m_own[j]);
        end
        e.load = ld;
    endtask

    task automatic drive(input logic r, input logic [3:0] rq, input logic [7:0] ds);
        exp_t e;
        rst      = r;
        bus.req  = rq;
        bus.dest = ds;
        model_step(r, rq, ds, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) rst_edge <= rst;

    // Monitor: scoreboard pop plus continuous protocol checks.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("grant",   int'(bus.grant),   int'(mon_e.grant));
            check("out_sel", int'(bus.out_sel), int'(mon_e.out_sel));
            check("out_en",  int'(bus.out_en),  int'(mon_e.out_en));
            check("load",    int'(bus.load),    int'(mon_e.load));
        end
        for (int j = 0; j < 4; j++) begin
            if (bus.out_en[j]) begin
                run_len[j]++;
            end else if (prev_en[j]) begin
                if (!rst_edge) check("hold_len", run_len[j], FL);
                run_len[j] = 0;
            end
            check("load_pulse", int'(bus.load[j]), int'(bus.out_en[j] && !prev_en[j]));
        end
        for (int i = 0; i < 4; i++) begin
            int c;
            c = 0;
            for (int j = 0; j < 4; j++)
                if (bus.out_en[j] && (int'(bus.out_sel[2*j +: 2]) == i)) c++;
            check("one_output", int'(c <= 1), 1);
            check("grant_cons", int'(bus.grant[i]), int'(c > 0));
        end
        if (rec_order && bus.load[0]) order0.push_back(int'(bus.out_sel[1:0]));
        prev_en = bus.out_en;
    end

    initial begin
        rst      = 1'b1;
        bus.req  = '0;
        bus.dest = '0;
        for (int j = 0; j < 4; j++) begin
            m_rem[j]   = 0;
            m_own[j]   = 0;
            m_ptr[j]   = 0;
            run_len[j] = 0;
        end

        drive(1'b1, 4'b0000, 8'h00);
        drive(1'b1, 4'b0000, 8'h00);

        // Single request: input 2 to output 1.
        drive(1'b0, 4'b0100, 8'h10);
        repeat (13) drive(1'b0, 4'b0000, 8'h00);

        // Contention: all inputs to output 0.
        rec_order = 1'b1;
        repeat (56) drive(1'b0, 4'b1111, 8'h00);
        rec_order = 1'b0;
        repeat (12) drive(1'b0, 4'b0000, 8'h00);
        check("rr_count", int'(order0.size() >= 5), 1);
        for (int k = 0; k < 5; k++)
            if (k < order0.size()) check("rr_order", order0[k], k % 4);

        // Parallel: input 0 to output 3, input 1 to output 2.
        drive(1'b0, 4'b0011, 8'b0000_1011);
        repeat (12) drive(1'b0, 4'b0000, 8'h00);

        // Early drop and dest change while granted.
        drive(1'b0, 4'b0010, 8'h00);
        drive(1'b0, 4'b0010, 8'h00);
        drive(1'b0, 4'b0010, 8'b0000_1100);
        repeat (14) drive(1'b0, 4'b0000, 8'h00);

        // Advance ptr[0] away from 0, then reset mid-frame with requests held.
        drive(1'b0, 4'b0001, 8'h00);
        repeat (11) drive(1'b0, 4'b0000, 8'h00);
        repeat (5) drive(1'b0, 4'b0011, 8'h00);
        drive(1'b1, 4'b0011, 8'h00);
        repeat (25) drive(1'b0, 4'b0011, 8'h00);
        repeat (12) drive(1'b0, 4'b0000, 8'h00);

        // Random traffic with occasional resets.
        repeat (1500) begin
            drive(1'b0 | ($urandom_range(0, 199) == 0), 4'($urandom), 8'($urandom));
        end
        repeat (12) drive(1'b0, 4'b0000, 8'h00);

        @(negedge clk);
        #1;
        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
